// File: rtl/data_path.sv
// K&S processor datapath: PC, IR, 4x16 register file, ALU, flag registers and RAM address/data muxing.
// Carries out the control unit's strobes each cycle and returns the decoded IR and the registered ALU flags.
package k_and_s_pkg;
    typedef enum logic [7:0] {
        I_NOP     = 8'h00,
        I_BRANCH  = 8'h01,
        I_BZERO   = 8'h02,
        I_BNEG    = 8'h03,
        I_BOV     = 8'h05,
        I_BNOV    = 8'h06,
        I_BNNEG   = 8'h0A,
        I_BNZERO  = 8'h0B,
        I_LOAD    = 8'h81,
        I_STORE   = 8'h82,
        I_MOVE    = 8'h91,
        I_ADD     = 8'hA1,
        I_SUB     = 8'hA2,
        I_AND     = 8'hA3,
        I_OR      = 8'hA4,
        I_HALT    = 8'hFF
    } decoded_instruction_type;
endpackage

module data_path
    import k_and_s_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int PC_RESET = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    write_reg_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [1:0]              operation,
    input  logic                    flags_reg_enable,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [15:0]             data_out,
    input  logic [15:0]             data_in
);

    // IR bit 7 is never consulted by any instruction, so only the opcode byte
    // and the low seven bits are held.
    logic [7:0]        ir_op;
    logic [6:0]        ir_lo;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       regs [4];

    logic [1:0]  a_sel;
    logic [1:0]  dst_sel;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [16:0] alu_wide;
    logic [15:0] alu_res;
    logic        alu_uov;
    logic        alu_sov;
    logic [15:0] wb_data;

    always_comb begin
        case (ir_op)
            8'h00:   decoded_instruction = I_NOP;
            8'h01:   decoded_instruction = I_BRANCH;
            8'h02:   decoded_instruction = I_BZERO;
            8'h03:   decoded_instruction = I_BNEG;
            8'h05:   decoded_instruction = I_BOV;
            8'h06:   decoded_instruction = I_BNOV;
            8'h0A:   decoded_instruction = I_BNNEG;
            8'h0B:   decoded_instruction = I_BNZERO;
            8'h81:   decoded_instruction = I_LOAD;
            8'h82:   decoded_instruction = I_STORE;
            8'h91:   decoded_instruction = I_MOVE;
            8'hA1:   decoded_instruction = I_ADD;
            8'hA2:   decoded_instruction = I_SUB;
            8'hA3:   decoded_instruction = I_AND;
            8'hA4:   decoded_instruction = I_OR;
            8'hFF:   decoded_instruction = I_HALT;
            default: decoded_instruction = I_NOP;
        endcase
    end

    // MOVE routes its source (IR[1:0]) through the A port with B zeroed, so ADD/OR pass it unchanged.
    always_comb begin
        a_sel = (decoded_instruction == I_MOVE) ? ir_lo[1:0] : ir_lo[3:2];
        alu_a = regs[a_sel];
        alu_b = (decoded_instruction == I_MOVE) ? 16'h0000 : regs[ir_lo[1:0]];
        case (decoded_instruction)
            I_LOAD:  dst_sel = ir_lo[6:5];
            I_MOVE:  dst_sel = ir_lo[3:2];
            default: dst_sel = ir_lo[5:4];
        endcase
    end

    always_comb begin
        alu_wide = 17'h00000;
        alu_uov  = 1'b0;
        alu_sov  = 1'b0;
        case (operation)
            2'b00: begin
                alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
                alu_uov  = alu_wide[16];
                alu_sov  = (alu_a[15] == alu_b[15]) && (alu_wide[15] != alu_a[15]);
            end
            2'b01: begin
                // Bit 16 of the zero-extended difference is the borrow, i.e. A < B unsigned.
                alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
                alu_uov  = alu_wide[16];
                alu_sov  = (alu_a[15] != alu_b[15]) && (alu_wide[15] != alu_a[15]);
            end
            2'b10:   alu_wide = {1'b0, alu_a & alu_b};
            default: alu_wide = {1'b0, alu_a | alu_b};
        endcase
        alu_res = alu_wide[15:0];
        wb_data = c_sel ? data_in : alu_res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= ADDR_W'(PC_RESET);
            ir_op <= 8'h00;
            ir_lo <= 7'h00;
        end else begin
            if (pc_enable)
                pc <= branch ? ir_lo[ADDR_W-1:0] : pc + ADDR_W'(1);
            if (ir_enable) begin
                ir_op <= data_in[15:8];
                ir_lo <= data_in[6:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++)
                regs[i] <= 16'h0000;
        end else if (write_reg_enable) begin
            regs[dst_sel] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_op           <= 1'b0;
            neg_op            <= 1'b0;
            unsigned_overflow <= 1'b0;
            signed_overflow   <= 1'b0;
        end else if (flags_reg_enable) begin
            zero_op           <= (alu_res == 16'h0000);
            neg_op            <= alu_res[15];
            unsigned_overflow <= alu_uov;
            signed_overflow   <= alu_sov;
        end
    end

    assign ram_addr = addr_sel ? ir_lo[ADDR_W-1:0] : pc;
    assign data_out = regs[ir_lo[6:5]];

endmodule

// File: tb/tb_data_path.sv
// Directed testbench for data_path: expectations are queued as each step is driven
// and popped when the corresponding DUT output is sampled.
module tb_data_path;
    import k_and_s_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        branch = 1'b0;
    logic        pc_enable = 1'b0;
    logic        ir_enable = 1'b0;
    logic        write_reg_enable = 1'b0;
    logic        addr_sel = 1'b0;
    logic        c_sel = 1'b0;
    logic [1:0]  operation = 2'b00;
    logic        flags_reg_enable = 1'b0;
    logic [15:0] data_in = 16'h0000;
    decoded_instruction_type decoded_instruction;
    logic        zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic [4:0]  ram_addr;
    logic [15:0] data_out;

    data_path #(.ADDR_W(5), .PC_RESET(0)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .write_reg_enable    (write_reg_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .flags_reg_enable    (flags_reg_enable),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .ram_addr            (ram_addr),
        .data_out            (data_out),
        .data_in             (data_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string tag, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h expected nothing queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    // Flags packed as {zero, neg, unsigned_ov, signed_ov}.
    function automatic logic [15:0] flags();
        return {12'h000, zero_op, neg_op, unsigned_overflow, signed_overflow};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [15:0] w);
        data_in   = w;
        ir_enable = 1'b1;
        step();
        ir_enable = 1'b0;
    endtask

    task automatic write_reg(input logic [1:0] r, input logic [15:0] v);
        load_ir(16'h8100 | (16'(r) << 5));
        data_in          = v;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        step();
        write_reg_enable = 1'b0;
        c_sel            = 1'b0;
    endtask

    task automatic read_reg(input string tag, input logic [1:0] r, input logic [15:0] v);
        push(tag, v);
        load_ir(16'h8200 | (16'(r) << 5));
        check(data_out);
    endtask

    task automatic alu_op(input logic [15:0] w, input logic [1:0] op);
        load_ir(w);
        operation        = op;
        flags_reg_enable = 1'b1;
        write_reg_enable = 1'b1;
        step();
        flags_reg_enable = 1'b0;
        write_reg_enable = 1'b0;
    endtask

    logic [7:0] dec_ops [19] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h0A, 8'h0B,
                                 8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF,
                                 8'h77, 8'h04, 8'hA5};
    decoded_instruction_type dec_exp [19] = '{I_NOP, I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV,
                                 I_BNNEG, I_BNZERO, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB,
                                 I_AND, I_OR, I_HALT, I_NOP, I_NOP, I_NOP};

    initial begin
        // Reset values while rst_n is held low from time zero.
        push("rst_ram_addr", 16'h0000);
        push("rst_decode", 16'(I_NOP));
        push("rst_flags", 16'h0000);
        push("rst_data_out", 16'h0000);
        #2;
        check(16'(ram_addr));
        check(16'(decoded_instruction));
        check(flags());
        check(data_out);
        #10 rst_n = 1'b1;
        step();

        // Jump PC to 3, then fetch a LOAD while advancing PC.
        load_ir(16'h0003);
        branch    = 1'b1;
        pc_enable = 1'b1;
        push("pc_branch_3", 16'h0003);
        step();
        branch    = 1'b0;
        pc_enable = 1'b0;
        check(16'(ram_addr));

        data_in   = 16'h8105;
        ir_enable = 1'b1;
        pc_enable = 1'b1;
        push("fetch_decode", 16'(I_LOAD));
        push("fetch_pc", 16'h0004);
        push("fetch_addr_ir", 16'h0005);
        step();
        ir_enable = 1'b0;
        pc_enable = 1'b0;
        check(16'(decoded_instruction));
        check(16'(ram_addr));
        addr_sel = 1'b1;
        #1;
        check(16'(ram_addr));
        addr_sel = 1'b0;

        // ADD with signed overflow: 7FFF + 0001.
        write_reg(2'd1, 16'h7FFF);
        write_reg(2'd2, 16'h0001);
        push("add_flags", 16'b0101);
        alu_op(16'hA106, 2'b00);
        check(flags());
        read_reg("add_r0", 2'd0, 16'h8000);

        // SUB with borrow: 0002 - 0003.
        write_reg(2'd1, 16'h0002);
        write_reg(2'd2, 16'h0003);
        push("sub_flags", 16'b0110);
        alu_op(16'hA236, 2'b01);
        check(flags());
        read_reg("sub_r3", 2'd3, 16'hFFFF);

        // Flags hold when a register write happens without flags_reg_enable.
        write_reg(2'd3, 16'h0000);
        push("flags_hold", 16'b0110);
        check(flags());

        // ADD with carry out to zero: FFFF + 0001 into R1.
        write_reg(2'd1, 16'hFFFF);
        write_reg(2'd2, 16'h0001);
        push("carry_flags", 16'b1010);
        alu_op(16'hA116, 2'b00);
        check(flags());
        read_reg("carry_r1", 2'd1, 16'h0000);

        // AND to zero, overflow flags cleared.
        write_reg(2'd1, 16'hF0F0);
        write_reg(2'd2, 16'h0F0F);
        push("and_flags", 16'b1000);
        alu_op(16'hA316, 2'b10);
        check(flags());

        // OR with result negative.
        write_reg(2'd1, 16'hF0F0);
        push("or_flags", 16'b0100);
        alu_op(16'hA416, 2'b11);
        check(flags());
        read_reg("or_r1", 2'd1, 16'hFFFF);

        // PC wrap 31 -> 0, then branch to 20, then hold.
        addr_sel = 1'b0;
        load_ir(16'h001F);
        branch    = 1'b1;
        pc_enable = 1'b1;
        push("pc_31", 16'd31);
        step();
        check(16'(ram_addr));
        branch = 1'b0;
        push("pc_wrap", 16'd0);
        step();
        pc_enable = 1'b0;
        check(16'(ram_addr));
        push("bzero_decode", 16'(I_BZERO));
        load_ir(16'h0214);
        check(16'(decoded_instruction));
        branch    = 1'b1;
        pc_enable = 1'b1;
        push("pc_branch_20", 16'd20);
        step();
        branch    = 1'b0;
        pc_enable = 1'b0;
        check(16'(ram_addr));
        push("pc_hold", 16'd20);
        step();
        check(16'(ram_addr));

        // MOVE R0 <= R2, then STORE presents R0 on data_out at address 7.
        write_reg(2'd2, 16'hABCD);
        load_ir(16'h9102);
        operation        = 2'b00;
        write_reg_enable = 1'b1;
        step();
        write_reg_enable = 1'b0;
        push("store_decode", 16'(I_STORE));
        push("store_data", 16'hABCD);
        push("store_addr", 16'h0007);
        load_ir(16'h8207);
        check(16'(decoded_instruction));
        check(data_out);
        addr_sel = 1'b1;
        #1;
        check(16'(ram_addr));
        addr_sel = 1'b0;

        // Full decode table including unassigned opcodes.
        for (int i = 0; i < 19; i++) begin
            push($sformatf("decode_%h", dec_ops[i]), 16'(dec_exp[i]));
            load_ir({dec_ops[i], 8'h00});
            check(16'(decoded_instruction));
        end

        // Reset asserted mid-cycle while strobes are active.
        data_in          = 16'hA116;
        ir_enable        = 1'b1;
        pc_enable        = 1'b1;
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
        push("midrst_ram_addr", 16'h0000);
        push("midrst_decode", 16'(I_NOP));
        push("midrst_flags", 16'h0000);
        push("midrst_data_out", 16'h0000);
        step();
        #2 rst_n = 1'b0;
        #1;
        check(16'(ram_addr));
        check(16'(decoded_instruction));
        check(flags());
        check(data_out);
        ir_enable        = 1'b0;
        pc_enable        = 1'b0;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        read_reg("midrst_r2", 2'd2, 16'h0000);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: observed %0d queued expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
